// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and helpers for the PWM output bank.
//   level_t / duty_t : level code and duty value at the default widths
//                      (LEVEL_W = 3, CNT_W = 16)
//   level_to_duty    : maps a level code to its duty target. The top level
//                      code gives full on (duty == period).
package pwm_pkg;

    localparam int unsigned PKG_LEVEL_W = 3;
    localparam int unsigned PKG_CNT_W   = 16;

    typedef logic [PKG_LEVEL_W-1:0] level_t;
    typedef logic [PKG_CNT_W-1:0]   duty_t;

    // STEP = period / level_max, truncated. The top code is forced to the
    // full period, so full on never loses cycles to the truncation.
    function automatic int unsigned level_to_duty(
        input int unsigned level,
        input int unsigned period,
        input int unsigned level_max
    );
        if (level >= level_max)
            return period;
        else
            return level * (period / level_max);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM channel of the output bank.
//   clk      : system clock, rising edge
//   reset    : synchronous, active-high
//   level    : level code, sampled only when boundary is high
//   enable   : channel enable. When low, pwm is forced low on the next edge
//              and duty clears at the next boundary
//   boundary : high on the last cycle of each period (cnt == PERIOD-1)
//   cnt      : shared period counter
//   pwm      : registered PWM output
//   settled  : duty equals the latched target
// Optional feature: define PWM_RAMP_EN to slew-limit duty changes to
// RAMP_STEP per period. Without it, duty jumps straight to the target.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned LEVEL_W   = 3,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned PERIOD    = 65535,
    parameter int unsigned RAMP_STEP = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] level,
    input  logic               enable,
    input  logic               boundary,
    input  logic [CNT_W-1:0]   cnt,
    output logic               pwm,
    output logic               settled
);

    localparam int unsigned LEVEL_MAX = (1 << LEVEL_W) - 1;

    if (RAMP_STEP < 1) begin : g_bad_ramp
        $error("pwm_channel: RAMP_STEP must be >= 1");
    end

    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] target_next;
    logic [CNT_W-1:0] duty_next;

    assign target_next = CNT_W'(level_to_duty(32'(level), PERIOD, LEVEL_MAX));

`ifdef PWM_RAMP_EN
    localparam longint unsigned DUTY_MAX = (64'd1 << CNT_W) - 64'd1;
    // A step wider than the whole duty range behaves like an unlimited step.
    localparam logic [CNT_W:0]  STEP_X   =
        (CNT_W+1)'((64'(RAMP_STEP) > DUTY_MAX) ? DUTY_MAX : 64'(RAMP_STEP));

    logic [CNT_W:0] duty_x;
    logic [CNT_W:0] tgt_x;

    // One extra bit so duty +/- step cannot wrap before the clamp.
    always_comb begin
        duty_x    = {1'b0, duty};
        tgt_x     = {1'b0, target_next};
        duty_next = target_next;
        if (tgt_x > duty_x) begin
            if (duty_x + STEP_X < tgt_x)
                duty_next = CNT_W'(duty_x + STEP_X);
        end else begin
            if (tgt_x + STEP_X < duty_x)
                duty_next = CNT_W'(duty_x - STEP_X);
        end
    end
`else
    assign duty_next = target_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            duty   <= '0;
            target <= '0;
            pwm    <= 1'b0;
        end else begin
            // Compare uses the pre-edge duty, so a new duty first shows
            // at cnt == 0 of the following period.
            pwm <= enable & (cnt < duty);
            if (boundary) begin
                target <= target_next;
                duty   <= enable ? duty_next : '0;
            end
        end
    end

    assign settled = (duty == target);

endmodule

// File: rtl/pwm_output_bank.sv
// pwm_output_bank: multi-channel PWM output stage driven by level codes.
//   CLK         : system clock, rising edge
//   Reset       : synchronous, active-high
//   Level       : packed level codes, channel i at [i*LEVEL_W +: LEVEL_W]
//   Enable      : per-channel enable
//   PWM         : registered PWM outputs
//   Settled     : per channel, duty equals the latched target
//   PeriodStart : one-cycle strobe aligned with the first PWM bit of a period
// Optional feature: PWM_RAMP_EN (see pwm_channel) enables slew limiting.
module pwm_output_bank
    import pwm_pkg::*;
#(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned LEVEL_W   = 3,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned PERIOD    = 65535,
    parameter int unsigned RAMP_STEP = 1024
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic [CHANNELS*LEVEL_W-1:0]   Level,
    input  logic [CHANNELS-1:0]           Enable,
    output logic [CHANNELS-1:0]           PWM,
    output logic [CHANNELS-1:0]           Settled,
    output logic                          PeriodStart
);

    localparam int unsigned     LEVEL_MAX = (1 << LEVEL_W) - 1;
    localparam longint unsigned CNT_MAX   = (64'd1 << CNT_W) - 64'd1;

    if (CHANNELS < 1) begin : g_bad_channels
        $error("pwm_output_bank: CHANNELS must be >= 1");
    end
    if (64'(PERIOD) < 64'(LEVEL_MAX) || 64'(PERIOD) > CNT_MAX) begin : g_bad_period
        $error("pwm_output_bank: PERIOD must lie in LEVEL_MAX .. 2**CNT_W-1");
    end

    logic [CNT_W-1:0] cnt;
    logic             boundary;

    assign boundary = (cnt == CNT_W'(PERIOD - 1));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt         <= '0;
            PeriodStart <= 1'b0;
        end else begin
            PeriodStart <= (cnt == '0);
            cnt         <= boundary ? '0 : cnt + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .LEVEL_W  (LEVEL_W),
            .CNT_W    (CNT_W),
            .PERIOD   (PERIOD),
            .RAMP_STEP(RAMP_STEP)
        ) u_ch (
            .clk     (CLK),
            .reset   (Reset),
            .level   (Level[i*LEVEL_W +: LEVEL_W]),
            .enable  (Enable[i]),
            .boundary(boundary),
            .cnt     (cnt),
            .pwm     (PWM[i]),
            .settled (Settled[i])
        );
    end

endmodule

// File: tb/tb_pwm_output_bank.sv
// tb_pwm_output_bank: self-checking bench for pwm_output_bank.
// Build with or without PWM_RAMP_EN; the reference model follows the macro.
module tb_pwm_output_bank;

    localparam int CH     = 2;
    localparam int LW     = 3;
    localparam int CW     = 16;
    localparam int PER    = 70;
    localparam int RAMP   = 20;
    localparam int LMAX   = (1 << LW) - 1;

    logic              CLK = 1'b0;
    logic              Reset;
    logic [CH*LW-1:0]  Level;
    logic [CH-1:0]     Enable;
    logic [CH-1:0]     PWM;
    logic [CH-1:0]     Settled;
    logic              PeriodStart;

    pwm_output_bank #(
        .CHANNELS (CH),
        .LEVEL_W  (LW),
        .CNT_W    (CW),
        .PERIOD   (PER),
        .RAMP_STEP(RAMP)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Level      (Level),
        .Enable     (Enable),
        .PWM        (PWM),
        .Settled    (Settled),
        .PeriodStart(PeriodStart)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: period position, per-channel duty and target as plain
    // integers, advanced once per clock from the rules of the block.
    int m_cnt = 0;
    int m_duty[CH];
    int m_tgt[CH];
    bit m_pwm[CH];
    bit m_ps = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_level(input int ch, input int lvl);
        Level[ch*LW +: LW] = LW'(lvl);
    endtask

    // Advance one clock: update model from the inputs the DUT sees at this
    // edge, then compare every output just after the edge.
    task automatic step();
        int lvl, diff;
        logic [CH-1:0] e_pwm, e_set;
        if (Reset) begin
            m_cnt = 0;
            m_ps  = 0;
            for (int i = 0; i < CH; i++) begin
                m_duty[i] = 0; m_tgt[i] = 0; m_pwm[i] = 0;
            end
        end else begin
            for (int i = 0; i < CH; i++)
                m_pwm[i] = Enable[i] && (m_cnt < m_duty[i]);
            m_ps = (m_cnt == 0);
            if (m_cnt == PER - 1) begin
                for (int i = 0; i < CH; i++) begin
                    lvl = int'(Level[i*LW +: LW]);
                    m_tgt[i] = (lvl == LMAX) ? PER : lvl * (PER / LMAX);
                    if (!Enable[i]) begin
                        m_duty[i] = 0;
                    end else begin
`ifdef PWM_RAMP_EN
                        diff = m_tgt[i] - m_duty[i];
                        if (diff > RAMP)  diff = RAMP;
                        if (diff < -RAMP) diff = -RAMP;
                        m_duty[i] = m_duty[i] + diff;
`else
                        diff = 0;
                        m_duty[i] = m_tgt[i];
`endif
                    end
                end
            end
            m_cnt = (m_cnt + 1) % PER;
        end
        @(posedge CLK);
        #1;
        for (int i = 0; i < CH; i++) begin
            e_pwm[i] = m_pwm[i];
            e_set[i] = (m_duty[i] == m_tgt[i]);
        end
        chk("pwm", 32'(PWM), 32'(e_pwm));
        chk("settled", 32'(Settled), 32'(e_set));
        chk("period_start", 32'(PeriodStart), 32'(m_ps));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Step until the counter reaches c; bounded to one period.
    task automatic advance_to(input int c);
        for (int k = 0; k < PER && m_cnt != c; k++) step();
        chk("advance_to", 32'(m_cnt), 32'(c));
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin
            m_duty[i] = 0; m_tgt[i] = 0; m_pwm[i] = 0;
        end
        Reset  = 1'b1;
        Level  = '0;
        Enable = 2'b11;
        run(3);
        chk("reset_pwm", 32'(PWM), 32'd0);
        chk("reset_ps", 32'(PeriodStart), 32'd0);
        chk("reset_settled", 32'(Settled), 32'd3);

        // Idle at level 0 for three periods.
        Reset = 1'b0;
        run(3 * PER);

        // Ch0 level 0 -> 3 just ahead of a boundary.
        advance_to(PER - 2);
        set_level(0, 3);
        run(3 * PER);

        // Ch0 up to full on, then back down to level 1.
        set_level(0, 7);
        run(5 * PER);
        chk("full_on_duty", 32'(m_duty[0]), 32'(PER));
        set_level(0, 1);
        run(5 * PER);

        // Mid-period glitch on Level is ignored.
        advance_to(35);
        set_level(0, 6);
        set_level(1, 5);
        advance_to(40);
        set_level(0, 1);
        set_level(1, 0);
        run(2 * PER);

        // Ch1 to duty 30, then disable mid-period and re-enable at level 2.
        set_level(1, 3);
        run(3 * PER);
        advance_to(10);
        Enable = 2'b01;
        run(2 * PER);
        chk("disabled_duty", 32'(m_duty[1]), 32'd0);
        set_level(1, 2);
        Enable = 2'b11;
        run(3 * PER);

        // Reset in the middle of a ramp.
        set_level(0, 0);
        run(2 * PER);
        set_level(0, 7);
        run(PER);
        advance_to(25);
        Reset = 1'b1;
        step();
        chk("midreset_pwm", 32'(PWM), 32'd0);
        chk("midreset_settled", 32'(Settled), 32'd3);
        Reset = 1'b0;
        run(3 * PER);

        // Randomised traffic.
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(7) == 0)
                set_level(int'($urandom_range(CH - 1)), int'($urandom_range(LMAX)));
            if ($urandom_range(39) == 0)
                Enable[$urandom_range(CH - 1)] ^= 1'b1;
            Reset = ($urandom_range(299) == 0);
            step();
        end
        Reset = 1'b0;
        run(PER);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
